// File: rtl/entier_en_vf_pkg.sv
// rtl/entier_en_vf_pkg.sv - shared constants and types for the integer-to-fixed-point decoder
//
// Purpose: single home for the word width, the lost-bit index, the most
// negative fixed-point value and the sign/positive-flag bit index. The
// decoder in this bundle and the existing encoder (encode_vf below) both
// take their constants from here so the two ends cannot drift apart.
// Ports: none (package).

package entier_en_vf_pkg;

  localparam int LARGEUR     = 16;
  localparam int BIT_PERDU   = 12;
  localparam int BIT_POSITIF = 15;
  localparam logic [15:0] VF_MIN = 16'h8000;

  typedef logic [LARGEUR-1:0] mot_t;

  // Contents of the output stage: decoded word plus its invalid marker.
  typedef struct packed {
    mot_t mot;
    logic invalide;
  } etage_t;

  // Encoder side of the code. Positive values carry a set flag bit; negative
  // values are inverted and lose bit BIT_PERDU, which is what makes codes
  // with that bit set (and the flag clear) invalid on the decode side.
  function automatic mot_t encode_vf(input mot_t vf);
    mot_t e;
    if (!vf[BIT_POSITIF]) begin
      e = vf;
      e[BIT_POSITIF] = 1'b1;
    end else begin
      e = ~vf;
      e[BIT_PERDU] = 1'b0;
    end
    return e;
  endfunction

endpackage

// File: rtl/entier_en_vf_if.sv
// rtl/entier_en_vf_if.sv - stream and statistics bundle of the decoder
//
// Purpose: groups the input stream, the output stream and the statistics
// signals of entier_en_vf.
// Signals:
//   entier_in / in_valid / in_ready   encoded word stream into the block
//   vf_out / out_valid / out_ready    decoded fixed-point stream out
//   code_invalide / nb_invalides      sticky flag and saturating counter
//   clr_stats                         synchronous clear of the statistics
// Modports: master = producer/consumer around the block, slave = the block.

interface entier_en_vf_if #(
  parameter int LARGEUR = entier_en_vf_pkg::LARGEUR,
  parameter int CPT_W   = 8
) ();

  logic [LARGEUR-1:0] entier_in;
  logic               in_valid;
  logic               in_ready;
  logic [LARGEUR-1:0] vf_out;
  logic               out_valid;
  logic               out_ready;
  logic               code_invalide;
  logic [CPT_W-1:0]   nb_invalides;
  logic               clr_stats;

  modport master (
    output entier_in, in_valid, out_ready, clr_stats,
    input  in_ready, vf_out, out_valid, code_invalide, nb_invalides
  );

  modport slave (
    input  entier_in, in_valid, out_ready, clr_stats,
    output in_ready, vf_out, out_valid, code_invalide, nb_invalides
  );

endinterface

// File: rtl/entier_en_vf_decode.sv
// rtl/entier_en_vf_decode.sv - pure combinational decode of one encoded word
//
// Purpose: maps an encoded word to its signed fixed-point value.
// Ports:
//   entier    in   encoded word
//   vf        out  decoded word (VF_MIN for invalid codes)
//   invalide  out  high when the code cannot have come from the encoder

module decode_entier_vf
  import entier_en_vf_pkg::*;
#(
  parameter int LARGEUR   = entier_en_vf_pkg::LARGEUR,
  parameter int BIT_PERDU = entier_en_vf_pkg::BIT_PERDU
) (
  input  logic [LARGEUR-1:0] entier,
  output logic [LARGEUR-1:0] vf,
  output logic               invalide
);

  always_comb begin
    vf       = ~entier;
    invalide = 1'b0;
    if (entier[BIT_POSITIF]) begin
      vf = {1'b0, entier[LARGEUR-2:0]};
    end else if (entier[BIT_PERDU]) begin
      // The encoder always clears this bit on negatives, so a set bit here
      // means the word is corrupt; clamp to the most negative value.
      vf       = VF_MIN;
      invalide = 1'b1;
    end else begin
      // The encoder dropped this bit; inverting a cleared bit restores the 1.
      vf[BIT_PERDU] = 1'b1;
    end
  end

endmodule

// File: rtl/entier_en_vf.sv
// rtl/entier_en_vf.sv - two-stage pipelined decoder with invalid-code statistics
//
// Purpose: accepts encoded words, decodes them to signed fixed point through
// a two-register pipeline (input word, then decoded word + invalid bit) with
// full valid/ready backpressure, and keeps a sticky invalid flag and a
// saturating invalid counter updated as words leave the block.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset, drops all words in flight
//   bus   slave modport of entier_en_vf_if (streams and statistics)

module entier_en_vf
  import entier_en_vf_pkg::*;
#(
  parameter int LARGEUR   = entier_en_vf_pkg::LARGEUR,
  parameter int BIT_PERDU = entier_en_vf_pkg::BIT_PERDU,
  parameter int CPT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  entier_en_vf_if.slave      bus
);

  logic               s1_valid_q, s1_valid_d;
  logic [LARGEUR-1:0] s1_mot_q, s1_mot_d;
  logic               s2_valid_q, s2_valid_d;
  etage_t             s2_q, s2_d;
  logic               code_inv_q, code_inv_d;
  logic [CPT_W-1:0]   nb_inv_q, nb_inv_d;

  logic [LARGEUR-1:0] vf_dec;
  logic               inv_dec;
  logic               s2_ready;
  logic               s1_avance;
  logic               in_ready_c;
  logic               accepte;
  logic               sortie;

  decode_entier_vf #(
    .LARGEUR   (LARGEUR),
    .BIT_PERDU (BIT_PERDU)
  ) u_decode (
    .entier   (s1_mot_q),
    .vf       (vf_dec),
    .invalide (inv_dec)
  );

  always_comb begin
    // Ready chain is built from stage state and out_ready only, never from
    // in_valid, so upstream can wait on in_ready without a loop.
    s2_ready   = !s2_valid_q || bus.out_ready;
    s1_avance  = s1_valid_q && s2_ready;
    in_ready_c = !s1_valid_q || s2_ready;
    accepte    = bus.in_valid && in_ready_c;
    sortie     = s2_valid_q && bus.out_ready;

    s1_valid_d = s1_valid_q;
    s1_mot_d   = s1_mot_q;
    if (accepte) begin
      s1_valid_d = 1'b1;
      s1_mot_d   = bus.entier_in;
    end else if (s1_avance) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s1_avance) begin
      s2_valid_d = 1'b1;
      s2_d       = '{mot: vf_dec, invalide: inv_dec};
    end else if (sortie) begin
      s2_valid_d = 1'b0;
    end

    // Statistics follow delivered words, not accepted ones; a clear in the
    // same cycle as an invalid delivery takes precedence.
    code_inv_d = code_inv_q;
    nb_inv_d   = nb_inv_q;
    if (bus.clr_stats) begin
      code_inv_d = 1'b0;
      nb_inv_d   = '0;
    end else if (sortie && s2_q.invalide) begin
      code_inv_d = 1'b1;
      if (nb_inv_q != {CPT_W{1'b1}}) begin
        nb_inv_d = nb_inv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mot_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      code_inv_q <= 1'b0;
      nb_inv_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mot_q   <= s1_mot_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
      code_inv_q <= code_inv_d;
      nb_inv_q   <= nb_inv_d;
    end
  end

  // The empty pipeline would otherwise advertise ready while reset is held.
  assign bus.in_ready      = in_ready_c && !rst;
  assign bus.vf_out        = s2_q.mot;
  assign bus.out_valid     = s2_valid_q;
  assign bus.code_invalide = code_inv_q;
  assign bus.nb_invalides  = nb_inv_q;

endmodule

// File: tb/tb_entier_en_vf.sv
// tb/tb_entier_en_vf.sv - self-checking bench for entier_en_vf

module tb_entier_en_vf;
  import entier_en_vf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  entier_en_vf_if #(.LARGEUR(16), .CPT_W(8)) bus_a ();
  entier_en_vf_if #(.LARGEUR(16), .CPT_W(2)) bus_b ();

  entier_en_vf #(.LARGEUR(16), .BIT_PERDU(12), .CPT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  entier_en_vf #(.LARGEUR(16), .BIT_PERDU(12), .CPT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nom, input logic [31:0] act, input logic [31:0] att);
    total++;
    if (act === att) passed++;
    else $display("FAIL %s: got %0h expected %0h", nom, act, att);
  endtask

  typedef struct {
    logic [15:0] e;
    logic [15:0] vf;
    logic        inv;
  } vect_t;

  vect_t vecs[9];

  logic [15:0] bp_mots[5];
  logic [15:0] bp_att[5];
  logic [15:0] rx[$];
  int          cnt_inv;
  logic        flag_inv;
  int          idx;
  logic        ir, ov;
  logic [15:0] vo;

  initial begin
    vecs[0] = '{16'h8123, 16'h0123, 1'b0};
    vecs[1] = '{16'h6EDC, 16'h9123, 1'b0};
    vecs[2] = '{16'h1000, 16'h8000, 1'b1};
    vecs[3] = '{16'h8000, 16'h0000, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h7FFF, 1'b0};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b0};
    vecs[6] = '{16'h0FFF, 16'hF000, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h8000, 1'b1};
    vecs[8] = '{16'h2ABC, 16'hD543, 1'b0};

    bp_mots = '{16'h8001, 16'h6EDC, 16'h8003, 16'h8004, 16'h8005};
    bp_att  = '{16'h0001, 16'h9123, 16'h0003, 16'h0004, 16'h0005};

    bus_a.entier_in = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.clr_stats = 1'b0;
    bus_b.entier_in = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.clr_stats = 1'b0;
    rst = 1'b1;

    // Reset state
    @(posedge clk); #1;
    bus_a.in_valid = 1'b1;
    #1;
    chk("rst in_ready", bus_a.in_ready, 1'b0);
    chk("rst out_valid", bus_a.out_valid, 1'b0);
    chk("rst vf_out", bus_a.vf_out, 16'h0000);
    chk("rst code_invalide", bus_a.code_invalide, 1'b0);
    chk("rst nb_invalides", bus_a.nb_invalides, 8'd0);
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", bus_a.in_ready, 1'b1);

    // Single-word vectors; latency counted in rising edges from the accepting edge
    cnt_inv  = 0;
    flag_inv = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus_a.entier_in = vecs[i].e;
      bus_a.in_valid  = 1'b1;
      bus_a.out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i), bus_a.in_ready, 1'b1);
      @(posedge clk); #1;
      bus_a.in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d out_valid edge1", i), bus_a.out_valid, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid edge2", i), bus_a.out_valid, 1'b1);
      chk($sformatf("v%0d vf_out", i), bus_a.vf_out, vecs[i].vf);
      chk($sformatf("v%0d nb before delivery", i), bus_a.nb_invalides, cnt_inv[7:0]);
      @(posedge clk); #1;
      if (vecs[i].inv) begin
        flag_inv = 1'b1;
        if (cnt_inv < 255) cnt_inv++;
      end
      chk($sformatf("v%0d out_valid drained", i), bus_a.out_valid, 1'b0);
      chk($sformatf("v%0d code_invalide", i), bus_a.code_invalide, flag_inv);
      chk($sformatf("v%0d nb_invalides", i), bus_a.nb_invalides, cnt_inv[7:0]);
    end

    // Backpressure: out_ready low for the first 4 cycles of a 5-word stream
    idx = 0;
    rx.delete();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bus_a.in_valid  = (idx < 5);
      bus_a.entier_in = (idx < 5) ? bp_mots[idx] : 16'h0000;
      bus_a.out_ready = (c >= 4);
      #1;
      ir = bus_a.in_ready;
      ov = bus_a.out_valid;
      vo = bus_a.vf_out;
      if (c == 2) begin
        chk("bp in_ready low when full", ir, 1'b0);
        chk("bp accepts before stall", idx, 2);
        chk("bp out_valid held", ov, 1'b1);
        chk("bp vf_out head", vo, bp_att[0]);
      end
      if (c == 3) begin
        chk("bp vf_out stable", vo, bp_att[0]);
        chk("bp out_valid still held", ov, 1'b1);
      end
      if (ov && bus_a.out_ready) rx.push_back(vo);
      if (bus_a.in_valid && ir) idx++;
      if (rx.size() >= 5 && idx >= 5) break;
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    chk("bp words delivered", rx.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp word %0d", k), (k < rx.size()) ? rx[k] : 16'hxxxx, bp_att[k]);
    end
    @(posedge clk); #1;
    chk("bp no duplicate", bus_a.out_valid, 1'b0);

    // Reset with two words in flight
    bus_a.in_valid  = 1'b1;
    bus_a.entier_in = 16'h8011;
    bus_a.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_a.entier_in = 16'h8012;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    chk("rs out_valid before reset", bus_a.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs out_valid dropped", bus_a.out_valid, 1'b0);
    chk("rs in_ready low", bus_a.in_ready, 1'b0);
    chk("rs vf_out cleared", bus_a.vf_out, 16'h0000);
    @(posedge clk); #3;
    rst = 1'b0;
    bus_a.out_ready = 1'b1;
    #1;
    chk("rs in_ready after release", bus_a.in_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rs no stale word %0d", k), bus_a.out_valid, 1'b0);
    end

    // Saturation on the 2-bit counter
    bus_b.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      bus_b.in_valid  = 1'b1;
      bus_b.entier_in = 16'h1000;
    end
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat nb_invalides", bus_b.nb_invalides, 2'd3);
    chk("sat code_invalide", bus_b.code_invalide, 1'b1);
    chk("sat drained", bus_b.out_valid, 1'b0);

    // Clear coincident with an invalid word leaving
    bus_b.in_valid  = 1'b1;
    bus_b.entier_in = 16'h7FFF;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr invalid word on output", bus_b.out_valid, 1'b1);
    chk("clr output value", bus_b.vf_out, 16'h8000);
    bus_b.clr_stats = 1'b1;
    @(posedge clk); #1;
    bus_b.clr_stats = 1'b0;
    chk("clr nb_invalides", bus_b.nb_invalides, 2'd0);
    chk("clr code_invalide", bus_b.code_invalide, 1'b0);

    // Counting resumes after the clear
    bus_b.in_valid  = 1'b1;
    bus_b.entier_in = 16'h1000;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("after clr nb_invalides", bus_b.nb_invalides, 2'd1);
    chk("after clr code_invalide", bus_b.code_invalide, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
